// File: rtl/hdmi_tx_rgb565_out_if.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_tx_rgb565_out_if
// Brief    : Frame-buffer FIFO read port plus RGB888 video bus of the HDMI TX.
// Revision : 1.0 - initial release
// ============================================================================
interface hdmi_tx_rgb565_out_if;
    logic        frame_req;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_empty;
    logic        hs_out;
    logic        vs_out;
    logic        de_out;
    logic [7:0]  r_out;
    logic [7:0]  g_out;
    logic [7:0]  b_out;

    modport master (
        output frame_req, rd_en, hs_out, vs_out, de_out, r_out, g_out, b_out,
        input  rd_data, rd_empty
    );

    modport slave (
        input  frame_req, rd_en, hs_out, vs_out, de_out, r_out, g_out, b_out,
        output rd_data, rd_empty
    );
endinterface
`default_nettype wire

// File: rtl/hdmi_tx_rgb565_out.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_tx_rgb565_out
// Brief    : Video timing generator pulling RGB565 from the frame-buffer FIFO
//            and driving RGB888 + hs/vs/de to the HDMI transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_tx_rgb565_out #(
    parameter int unsigned H_ACTIVE     = 1280,
    parameter int unsigned H_FP         = 110,
    parameter int unsigned H_SYNC       = 40,
    parameter int unsigned H_BP         = 220,
    parameter int unsigned V_ACTIVE     = 720,
    parameter int unsigned V_FP         = 5,
    parameter int unsigned V_SYNC       = 5,
    parameter int unsigned V_BP         = 20,
    parameter bit          HS_POL       = 1'b1,
    parameter bit          VS_POL       = 1'b1,
    parameter int unsigned PREFETCH_CYC = 64
) (
    input  wire logic             pixclk_out,
    input  wire logic             rstn_out,
    input  wire logic             init_over_tx,
    input  wire logic             underflow_clr,
    output logic                  underflow,
    hdmi_tx_rgb565_out_if.master  tx_if
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [7:0]    PF_LAST = 8'(PREFETCH_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREFETCH = 2'd1,
        S_RUN      = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     init_sync_q;
    logic           init_s;
    logic [HW-1:0]  h_cnt_q, h_cnt_d;
    logic [VW-1:0]  v_cnt_q, v_cnt_d;
    logic [7:0]     pf_cnt_q, pf_cnt_d;
    logic           req_done_q, req_done_d;
    logic           req_pulse;

    logic           rd_en_s0;
    logic           hs_s0;
    logic           vs_s0;

    logic           de_s1_q, hs_s1_q, vs_s1_q, und_s1_q;
    logic           de_q, hs_q, vs_q;
    logic [7:0]     r_q, g_q, b_q;
    logic           underflow_q;

    logic [7:0]     r_exp, g_exp, b_exp;

    // init_over_tx comes from the configuration clock domain
    always_ff @(posedge pixclk_out or negedge rstn_out) begin
        if (!rstn_out) begin
            init_sync_q <= 2'b00;
        end else begin
            init_sync_q <= {init_sync_q[0], init_over_tx};
        end
    end
    assign init_s = init_sync_q[1];

    always_ff @(posedge pixclk_out or negedge rstn_out) begin
        if (!rstn_out) begin
            state_q    <= S_IDLE;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            pf_cnt_q   <= '0;
            req_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            pf_cnt_q   <= pf_cnt_d;
            req_done_q <= req_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        pf_cnt_d   = pf_cnt_q;
        req_done_d = req_done_q;
        req_pulse  = 1'b0;
        case (state_q)
            S_IDLE: begin
                h_cnt_d    = '0;
                v_cnt_d    = '0;
                pf_cnt_d   = '0;
                req_done_d = 1'b0;
                if (init_s) begin
                    state_d = S_PREFETCH;
                end
            end
            S_PREFETCH: begin
                h_cnt_d   = '0;
                v_cnt_d   = '0;
                req_pulse = (pf_cnt_q == 8'd0);
                pf_cnt_d  = pf_cnt_q + 8'd1;
                if (pf_cnt_q == PF_LAST) begin
                    pf_cnt_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
                end else begin
                    h_cnt_d = h_cnt_q + 1'b1;
                end
                // Rewind request one line ahead, only if another frame will follow
                if ((v_cnt_q == V_LAST) && (h_cnt_q == '0) && init_s) begin
                    req_pulse  = 1'b1;
                    req_done_d = 1'b1;
                end
                if ((v_cnt_q == V_LAST) && (h_cnt_q == H_LAST)) begin
                    req_done_d = 1'b0;
                    if (!init_s) begin
                        state_d = S_IDLE;
                    end else if (!req_done_q) begin
                        // init re-rose after the rewind point: rewind and prefetch again
                        state_d = S_PREFETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rd_en_s0 = (state_q == S_RUN) && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hs_s0    = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vs_s0    = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

    assign r_exp = {tx_if.rd_data[15:11], tx_if.rd_data[15:13]};
    assign g_exp = {tx_if.rd_data[10:5],  tx_if.rd_data[10:9]};
    assign b_exp = {tx_if.rd_data[4:0],   tx_if.rd_data[4:2]};

    always_ff @(posedge pixclk_out or negedge rstn_out) begin
        if (!rstn_out) begin
            de_s1_q  <= 1'b0;
            hs_s1_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            und_s1_q <= 1'b0;
            de_q     <= 1'b0;
            hs_q     <= ~HS_POL;
            vs_q     <= ~VS_POL;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            de_s1_q  <= rd_en_s0;
            hs_s1_q  <= hs_s0;
            vs_s1_q  <= vs_s0;
            und_s1_q <= rd_en_s0 && tx_if.rd_empty;
            de_q     <= de_s1_q;
            hs_q     <= hs_s1_q ^ ~HS_POL;
            vs_q     <= vs_s1_q ^ ~VS_POL;
            // Blanking and underflowed pixels are forced to black
            if (de_s1_q && !und_s1_q) begin
                r_q <= r_exp;
                g_q <= g_exp;
                b_q <= b_exp;
            end else begin
                r_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end
        end
    end

    always_ff @(posedge pixclk_out or negedge rstn_out) begin
        if (!rstn_out) begin
            underflow_q <= 1'b0;
        end else if (rd_en_s0 && tx_if.rd_empty) begin
            underflow_q <= 1'b1;
        end else if (underflow_clr) begin
            underflow_q <= 1'b0;
        end
    end

    assign underflow       = underflow_q;
    assign tx_if.frame_req = req_pulse;
    assign tx_if.rd_en     = rd_en_s0;
    assign tx_if.de_out    = de_q;
    assign tx_if.hs_out    = hs_q;
    assign tx_if.vs_out    = vs_q;
    assign tx_if.r_out     = r_q;
    assign tx_if.g_out     = g_q;
    assign tx_if.b_out     = b_q;

endmodule
`default_nettype wire
